// File: rtl/sample_scheduler_pkg.sv
// rtl/sample_scheduler_pkg.sv - shared types, constants and sample conversion for sample_scheduler
package sample_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      STORE,
      DAC_REQ,
      DAC_WAIT
   } sched_state_t;

   localparam int          MIN_PERIOD = 64;
   localparam int          SAMPLE_W   = 14;
   localparam logic [11:0] MIDSCALE   = 12'h800;

   // Two's-complement 14-bit to offset-binary 12-bit: flip the sign bit, drop two LSBs.
   function automatic logic [11:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
      return 12'((s ^ 14'h2000) >> 2);
   endfunction

endpackage

// File: rtl/sample_scheduler_delay.sv
// rtl/sample_scheduler_delay.sv - sample_delay_line: ring of past samples with offset read
module sample_delay_line
   import sample_scheduler_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [SAMPLE_W-1:0]   wdata,
   input  logic [DEPTH_LOG2-1:0] rd_offset,
   output logic [SAMPLE_W-1:0]   rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [SAMPLE_W-1:0]   mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (we) begin
         wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Offset 0 addresses the slot about to be written; the caller bypasses that case.
   assign rd_data = mem[wr_ptr - rd_offset];

endmodule

// File: rtl/sample_scheduler.sv
// rtl/sample_scheduler.sv - one-domain FSM sequencing ADC conversion and DAC A/B update per period
module sample_scheduler
   import sample_scheduler_pkg::*;
#(
   parameter int PERIOD_W    = 16,
   parameter int DEPTH_LOG2  = 4,
   parameter int ADC_TIMEOUT = 255
)
(
   input  logic                  CLK_50M,
   input  logic                  RESET,
   input  logic [PERIOD_W-1:0]   period,
   input  logic [DEPTH_LOG2-1:0] delay_sel,
   output logic                  adc_start,
   input  logic                  adc_done,
   input  logic [13:0]           adc_va,
   output logic                  dac_start,
   input  logic                  dac_busy,
   output logic [11:0]           dac_va,
   output logic [11:0]           dac_vb,
   output logic                  overrun,
   output logic                  timeout,
   input  logic                  clear_flags
);

   localparam int                  TW    = $clog2(ADC_TIMEOUT + 1);
   localparam logic [TW-1:0]       T_MAX = TW'(ADC_TIMEOUT - 1);
   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

   sched_state_t          state, state_nxt;
   logic                  adc_start_nxt, dac_start_nxt;
   logic                  issued, issued_nxt;
   logic [PERIOD_W-1:0]   cnt, cur_period, eff_period;
   logic                  tick;
   logic [TW-1:0]         tcnt;
   logic [SAMPLE_W-1:0]   sample, rd_data;
   logic [DEPTH_LOG2-1:0] fill;
   logic                  conv_timeout;

   assign eff_period   = (period < MIN_P) ? MIN_P : period;
   assign conv_timeout = (state == CONV) && !adc_done && (tcnt == T_MAX);

   // Period is sampled only at wrap so a change never truncates the running period.
   always_ff @(posedge CLK_50M or posedge RESET) begin
      if (RESET) begin
         cnt        <= '0;
         cur_period <= MIN_P;
         tick       <= 1'b0;
      end else if (cnt == cur_period - ONE_P) begin
         cnt        <= '0;
         cur_period <= eff_period;
         tick       <= 1'b1;
      end else begin
         cnt        <= cnt + ONE_P;
         tick       <= 1'b0;
      end
   end

   always_comb begin
      state_nxt     = state;
      adc_start_nxt = 1'b0;
      dac_start_nxt = 1'b0;
      issued_nxt    = issued;
      case (state)
         IDLE: begin
            if (tick) begin
               state_nxt     = CONV;
               adc_start_nxt = 1'b1;
            end
         end
         CONV: begin
            if (adc_done) begin
               state_nxt = STORE;
            end else if (conv_timeout) begin
               state_nxt = IDLE;
            end
         end
         STORE: begin
            state_nxt     = DAC_REQ;
            dac_start_nxt = !dac_busy;
            issued_nxt    = !dac_busy;
         end
         DAC_REQ: begin
            // If the driver was still busy from earlier, hold the request until it frees up.
            if (issued) begin
               if (dac_busy) begin
                  state_nxt = DAC_WAIT;
               end
            end else if (!dac_busy) begin
               dac_start_nxt = 1'b1;
               issued_nxt    = 1'b1;
            end
         end
         DAC_WAIT: begin
            if (!dac_busy) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50M or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         adc_start <= 1'b0;
         dac_start <= 1'b0;
         issued    <= 1'b0;
         tcnt      <= '0;
         sample    <= '0;
         fill      <= '0;
         dac_va    <= MIDSCALE;
         dac_vb    <= MIDSCALE;
         overrun   <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         adc_start <= adc_start_nxt;
         dac_start <= dac_start_nxt;
         issued    <= issued_nxt;
         tcnt      <= (state == CONV && !adc_done) ? tcnt + TW'(1) : '0;

         if (state == CONV && adc_done) begin
            sample <= adc_va;
            dac_va <= to_offset_binary(adc_va);
            if (delay_sel == '0) begin
               dac_vb <= to_offset_binary(adc_va);
            end else if (fill < delay_sel) begin
               dac_vb <= MIDSCALE;
            end else begin
               dac_vb <= to_offset_binary(rd_data);
            end
         end

         if (state == STORE && fill != '1) begin
            fill <= fill + DEPTH_LOG2'(1);
         end

         if (tick && state != IDLE) begin
            overrun <= 1'b1;
         end else if (clear_flags) begin
            overrun <= 1'b0;
         end

         if (conv_timeout) begin
            timeout <= 1'b1;
         end else if (clear_flags) begin
            timeout <= 1'b0;
         end
      end
   end

   sample_delay_line #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_delay (
      .clk       (CLK_50M),
      .rst       (RESET),
      .we        (state == STORE),
      .wdata     (sample),
      .rd_offset (delay_sel),
      .rd_data   (rd_data)
   );

endmodule

// File: tb/tb_sample_scheduler.sv
// tb/tb_sample_scheduler.sv - directed self-checking bench for sample_scheduler
module tb_sample_scheduler;

   logic        CLK_50M = 1'b0;
   logic        RESET   = 1'b1;
   logic [15:0] period  = 16'd100;
   logic [3:0]  delay_sel = 4'd0;
   logic        adc_start;
   logic        adc_done = 1'b0;
   logic [13:0] adc_va   = 14'h0;
   logic        dac_start;
   logic        dac_busy = 1'b0;
   logic [11:0] dac_va, dac_vb;
   logic        overrun, timeout;
   logic        clear_flags = 1'b0;

   int vecs = 0;
   int miscompares = 0;
   int cyc = 0;
   int n_astart = 0, n_dstart = 0, busy_viol = 0;
   int t_astart = 0, t_dstart = 0, t_adone = 0;
   int adc_lat = 20, adc_cnt = 0;
   int busy_len = 3, busy_cnt = 0;
   bit start_pend = 1'b0;
   logic [13:0] adc_sample = 14'h1FFF;
   logic [11:0] va, vb;

   sample_scheduler #(
      .PERIOD_W    (16),
      .DEPTH_LOG2  (4),
      .ADC_TIMEOUT (255)
   ) dut (
      .CLK_50M     (CLK_50M),
      .RESET       (RESET),
      .period      (period),
      .delay_sel   (delay_sel),
      .adc_start   (adc_start),
      .adc_done    (adc_done),
      .adc_va      (adc_va),
      .dac_start   (dac_start),
      .dac_busy    (dac_busy),
      .dac_va      (dac_va),
      .dac_vb      (dac_vb),
      .overrun     (overrun),
      .timeout     (timeout),
      .clear_flags (clear_flags)
   );

   always #10 CLK_50M = ~CLK_50M;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs just after the edge, then drive the ADC/DAC driver models.
   task automatic step();
      @(posedge CLK_50M);
      #1;
      cyc++;
      if (dac_start && dac_busy) busy_viol++;
      if (dac_start) begin n_dstart++; t_dstart = cyc; end
      if (adc_start) begin n_astart++; t_astart = cyc; end
      if (busy_cnt > 0) busy_cnt--;
      if (start_pend) begin busy_cnt = busy_len; start_pend = 1'b0; end
      if (dac_start) start_pend = 1'b1;
      dac_busy = (busy_cnt > 0);
      adc_done = 1'b0;
      if (adc_cnt > 0) begin
         adc_cnt--;
         if (adc_cnt == 0) begin
            adc_done = 1'b1;
            adc_va   = adc_sample;
            t_adone  = cyc;
         end
      end
      if (adc_start && adc_lat > 0) adc_cnt = adc_lat;
   endtask

   task automatic step_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      adc_cnt = 0; busy_cnt = 0; start_pend = 1'b0;
      dac_busy = 1'b0; adc_done = 1'b0; clear_flags = 1'b0;
      step();
      step();
      RESET = 1'b0;
      cyc = 0; n_astart = 0; n_dstart = 0;
   endtask

   task automatic wait_astart(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && n_astart < target; i++) step();
      check(tag, n_astart, target);
   endtask

   task automatic wait_dstart(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && n_dstart < target; i++) step();
      check(tag, n_dstart, target);
   endtask

   task automatic period_cycle(input logic [13:0] s, input string tag);
      adc_sample = s;
      wait_dstart(n_dstart + 1, 200, tag);
      va = dac_va;
      vb = dac_vb;
   endtask

   initial begin
      // Reset values
      step();
      check("rst_dac_va", dac_va, 12'h800);
      check("rst_dac_vb", dac_vb, 12'h800);
      check("rst_adc_start", adc_start, 1'b0);
      check("rst_dac_start", dac_start, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_timeout", timeout, 1'b0);

      // Full-scale positive sample, period 100, delay 0
      period = 16'd100; delay_sel = 4'd0; adc_lat = 20; busy_len = 3; adc_sample = 14'h1FFF;
      do_reset();
      wait_astart(1, 200, "a_start1_seen");
      check("a_start1_cyc", t_astart, 65);
      wait_dstart(1, 100, "a_dstart_seen");
      check("a_dac_va", dac_va, 12'hFFF);
      check("a_dac_vb", dac_vb, 12'hFFF);
      check("a_dstart_lat", t_dstart - t_adone, 2);
      wait_astart(2, 200, "a_start2_seen");
      check("a_start2_cyc", t_astart, 165);
      wait_astart(3, 200, "a_start3_seen");
      check("a_start3_cyc", t_astart, 265);

      // One-period delay with fill
      period = 16'd64; delay_sel = 4'd1;
      do_reset();
      period_cycle(14'h0000, "b0_seen");
      check("b0_va", va, 12'h800); check("b0_vb", vb, 12'h800);
      period_cycle(14'h2000, "b1_seen");
      check("b1_va", va, 12'h000); check("b1_vb", vb, 12'h800);
      period_cycle(14'h1000, "b2_seen");
      check("b2_va", va, 12'hC00); check("b2_vb", vb, 12'h000);

      // Maximum delay with a ramp, across pointer wrap
      delay_sel = 4'd15;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         period_cycle(14'(4 * i), $sformatf("c%0d_seen", i));
         check($sformatf("c%0d_va", i), va, 12'h800 + 12'(i));
         check($sformatf("c%0d_vb", i), vb, (i < 15) ? 12'h800 : 12'h800 + 12'(i - 15));
      end

      // ADC never answers
      period = 16'd300; delay_sel = 4'd0; adc_lat = 0;
      do_reset();
      wait_astart(1, 200, "d_start1_seen");
      check("d_start1_cyc", t_astart, 65);
      step_until(318);
      check("d_timeout_early", timeout, 1'b0);
      step_until(321);
      check("d_timeout_set", timeout, 1'b1);
      check("d_no_dstart", n_dstart, 0);
      adc_lat = 20;
      wait_astart(2, 200, "d_start2_seen");
      check("d_start2_cyc", t_astart, 365);
      check("d_no_overrun", overrun, 1'b0);
      wait_dstart(1, 100, "d_dstart_seen");
      check("d_dstart_cyc", t_dstart, 387);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      step();
      check("d_timeout_clr", timeout, 1'b0);

      // Clamped period with long DAC busy
      period = 16'd10; busy_len = 80;
      do_reset();
      wait_astart(1, 200, "e_start1_seen");
      check("e_start1_cyc", t_astart, 65);
      step_until(128);
      check("e_overrun_pre", overrun, 1'b0);
      step_until(130);
      check("e_overrun_set", overrun, 1'b1);
      wait_astart(2, 200, "e_start2_seen");
      check("e_start2_cyc", t_astart, 193);
      step_until(300);
      check("e_dstart_count", n_dstart, 2);

      // Reset while waiting on the DAC
      period = 16'd64; busy_len = 30; adc_sample = 14'h1FFF;
      do_reset();
      wait_dstart(1, 200, "f_dstart_seen");
      check("f_dstart_cyc", t_dstart, 87);
      step_until(100);
      check("f_dac_va_pre", dac_va, 12'hFFF);
      RESET = 1'b1;
      #1;
      check("f_rst_dac_va", dac_va, 12'h800);
      check("f_rst_dac_vb", dac_vb, 12'h800);
      check("f_rst_dac_start", dac_start, 1'b0);
      check("f_rst_adc_start", adc_start, 1'b0);
      busy_len = 3;
      do_reset();
      wait_astart(1, 200, "f_start_seen");
      check("f_start_cyc", t_astart, 65);

      check("dac_start_while_busy", busy_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/sample_scheduler.md
# sample_scheduler

Sequences one sampling period of the ADC→DAC relay path: issues the ADC conversion start at a programmable rate and captures the channel-A sample. It then updates both DAC channels: DAC A gets the current sample, DAC B gets the same sample delayed by a programmable number (0-15) of sampling periods. The block sits between the ADC driver and the DAC driver and replaces ad-hoc strobe/clock gating with one clock-domain FSM.

## Interface
- PERIOD_W, 16: width of the sampling-period count.
- DEPTH_LOG2, 4: log2 of delay-line depth; max delay is 2^DEPTH_LOG2-1.
- ADC_TIMEOUT, 255: cycles to wait for adc_done before aborting.

- CLK_50M  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- period  in  PERIOD_W  sampling period in clocks; values below 64 are treated as 64.
- delay_sel  in  DEPTH_LOG2  DAC B delay in sampling periods.
- adc_start  out  1  one-cycle conversion request to the ADC driver.
- adc_done  in  1  one-cycle pulse: adc_va valid this cycle.
- adc_va  in  14  two's-complement ADC channel-A sample.
- dac_start  out  1  one-cycle update request to the DAC driver.
- dac_busy  in  1  high while the DAC driver is shifting.
- dac_va  out  12  DAC A code, offset binary.
- dac_vb  out  12  DAC B code, offset binary.
- overrun  out  1  sticky: a period tick arrived while the FSM was not IDLE.
- timeout  out  1  sticky: adc_done was not seen within ADC_TIMEOUT cycles.
- clear_flags  in  1  synchronous clear of overrun and timeout.

## Operation
- Period counter counts 0..eff_period-1 and emits a tick on wrap, with eff_period = max(period, 64).
  - A period change takes effect at the next wrap.
- FSM states: IDLE, CONV, STORE, DAC_REQ, DAC_WAIT.
- IDLE: on tick, pulse adc_start for one cycle and go to CONV.
- CONV: wait for adc_done.
  - On adc_done, latch adc_va and go to STORE.
  - After ADC_TIMEOUT cycles without adc_done, set timeout and return to IDLE; no DAC update, no buffer write.
- STORE, one cycle:
  - Write the latched sample at wr_ptr, then advance wr_ptr (mod 2^DEPTH_LOG2).
  - Register dac_va = {~s[13], s[12:2]}.
  - Register dac_vb from the entry written delay_sel samples earlier, converted the same way. delay_sel=0 gives dac_vb = dac_va.
  - Until delay_sel samples have been written since reset, dac_vb = 12'h800 (midscale). A fill counter saturates at 2^DEPTH_LOG2-1.
- DAC_REQ: pulse dac_start for one cycle, then wait for dac_busy to go high.
  - If dac_busy is already high on entry, wait for it to go low, then re-issue dac_start.
- DAC_WAIT: wait for dac_busy to go low, then go to IDLE.
- A tick in any state other than IDLE is dropped and sets overrun; the FSM is not disturbed.
- Changing delay_sel mid-run takes effect at the next STORE; the fill counter is not reset.
- clear_flags coinciding with a new flag event: the set wins.

## Timing
- Reset values: all outputs 0 except dac_va = dac_vb = 12'h800; FSM = IDLE; counters and pointers 0.
- Reset mid-operation aborts any transfer immediately. Buffer contents are don't-care because the fill counter is cleared.
- adc_start is asserted in the cycle after the tick.
- dac_va/dac_vb update in the cycle after adc_done and stay stable until the next STORE.
- dac_start is asserted 2 cycles after adc_done and is never asserted while dac_busy is high.
- Wrap-around: wr_ptr and the read index (wr_ptr - delay_sel) are computed modulo 2^DEPTH_LOG2.

## Structure
- Shared package holds:
  - the FSM state enum;
  - MIN_PERIOD = 64;
  - MIDSCALE = 12'h800;
  - the 14→12 offset-binary conversion function.
- Sub-module: sample_delay_line, a 2^DEPTH_LOG2 × 14 register ring with write port and offset-read port.

## Test plan
- period=100, delay_sel=0, ADC model returns 14'h1FFF after 20 cycles -> adc_start every 100 cycles; dac_va = dac_vb = 12'hFFF; dac_start 2 cycles after adc_done.
- delay_sel=1, samples 14'h0000, 14'h2000, 14'h1000 -> dac_vb = 12'h800 (fill), then 12'h800, then 12'h000; dac_va = 12'h800, 12'h000, 12'hC00.
- delay_sel=15 with ramp samples 0,4,8,… -> dac_vb is midscale for the first 15 updates, then equals dac_va from 15 periods earlier across the pointer wrap.
- ADC model never asserts adc_done -> timeout sets after 255 cycles; no dac_start; FSM resumes at the next tick; clear_flags clears timeout.
- period=10 (clamped to 64) with dac_busy held 80 cycles -> overrun set; exactly one dac_start per completed cycle; no dac_start while busy.
- RESET asserted in DAC_WAIT -> all outputs at reset values next edge; after release, the first adc_start occurs 64+1 cycles later with period ≤ 64.
